window_sum_mc: RTL and testbench

//  Multi-channel sliding-window sum for SAD cost aggregation in the stereo depth pipeline.

---
 rtl/window_sum_mc_if.sv | 32 +++
 rtl/window_sum_mc.sv | 121 ++++++++++++
 tb/tb_window_sum_mc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_sum_mc_if.sv
// ============================================================================
// Module  : window_sum_mc_if
// Purpose : Sample-in / sum-out bundle for the multi-channel window summer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface window_sum_mc_if #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 11,
    parameter int OUT_W  = 14
);
    logic                    in_valid;
    logic                    in_sol;
    logic [NUM_CH*IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_full;
    logic                    out_sol;
    logic [NUM_CH*OUT_W-1:0] out_sum;

    modport master (
        output in_valid, in_sol, in_data,
        input  out_valid, out_full, out_sol, out_sum
    );

    modport slave (
        input  in_valid, in_sol, in_data,
        output out_valid, out_full, out_sol, out_sum
    );
endinterface

`default_nettype wire

// File: rtl/window_sum_mc.sv
// ============================================================================
// Module  : window_sum_mc
// Purpose : Per-lane sliding-window sum of the last WIN samples with line restart.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module window_sum_mc #(
    parameter int NUM_CH       = 4,
    parameter int IN_W         = 11,
    parameter int WIN          = 5,
    parameter int OUT_W        = 14,
    parameter int EMIT_PARTIAL = 0
) (
    input  logic           clock,
    input  logic           reset,
    window_sum_mc_if.slave bus
);
    localparam int PTR_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int CNT_W = $clog2(WIN + 1);
    localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WIN - 1);

    generate
        if (WIN < 1 || WIN > 64) begin : g_bad_win
            $error("window_sum_mc: WIN must be in 1..64");
        end
        if (OUT_W < IN_W + $clog2(WIN)) begin : g_bad_out_w
            $error("window_sum_mc: OUT_W too narrow for IN_W and WIN");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [PTR_W-1:0]        ptr;
    logic [NUM_CH*OUT_W-1:0] sum_q;
    logic                    sol_pending;

    logic                    drop_old;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        ptr_next;
    logic [CNT_W-1:0]        count_next;
    logic                    full_next;
    logic                    emit;
    wire  [NUM_CH*OUT_W-1:0] sum_d;

    // Entries behind the pointer are stale until the window has filled once,
    // so the subtracted term is forced to zero outside RUN and on line restart.
    always_comb begin
        drop_old = (state != RUN) || bus.in_sol;
        wr_ptr   = bus.in_sol ? '0 : ptr;
        ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (bus.in_sol)
            count_next = CNT_W'(1);
        else if (count == WIN_CNT)
            count_next = WIN_CNT;
        else
            count_next = count + 1'b1;
        full_next = (count_next == WIN_CNT);
        emit      = (EMIT_PARTIAL != 0) || full_next;
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
            logic [IN_W-1:0]  mem [WIN];
            logic [IN_W-1:0]  sample;
            logic [IN_W-1:0]  oldest;
            logic [OUT_W-1:0] sum_cur;

            assign sample  = bus.in_data[k*IN_W +: IN_W];
            assign oldest  = drop_old ? '0 : mem[ptr];
            assign sum_cur = sum_q[k*OUT_W +: OUT_W];
            // Intermediate sum+in may wrap; the final difference is exact mod 2^OUT_W.
            assign sum_d[k*OUT_W +: OUT_W] = bus.in_sol ? OUT_W'(sample)
                                           : sum_cur + OUT_W'(sample) - OUT_W'(oldest);

            always_ff @(posedge clock) begin
                if (bus.in_valid)
                    mem[wr_ptr] <= sample;
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            ptr           <= '0;
            sum_q         <= '0;
            sol_pending   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_full  <= 1'b0;
            bus.out_sol   <= 1'b0;
            bus.out_sum   <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.in_valid) begin
                state       <= full_next ? RUN : FILL;
                count       <= count_next;
                ptr         <= ptr_next;
                sum_q       <= sum_d;
                // A suppressed line start is carried to the first emitted result.
                sol_pending <= emit ? 1'b0 : (bus.in_sol | sol_pending);
                if (emit) begin
                    bus.out_valid <= 1'b1;
                    bus.out_full  <= full_next;
                    bus.out_sol   <= bus.in_sol | sol_pending;
                    bus.out_sum   <= sum_d;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_window_sum_mc.sv
// ============================================================================
// Module  : tb_window_sum_mc
// Purpose : Scoreboard bench for window_sum_mc, partial and full-only emit modes.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_window_sum_mc;
    localparam int NUM_CH = 2;
    localparam int IN_W   = 11;
    localparam int WIN    = 5;
    localparam int OUT_W  = 14;
    localparam int DW     = NUM_CH * IN_W;
    localparam int SW     = NUM_CH * OUT_W;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic          full;
        logic          sol;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    window_sum_mc_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus_p ();
    window_sum_mc_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus_f ();

    window_sum_mc #(.NUM_CH(NUM_CH), .IN_W(IN_W), .WIN(WIN), .OUT_W(OUT_W), .EMIT_PARTIAL(1)) dut_p (
        .clock (clock),
        .reset (reset),
        .bus   (bus_p)
    );

    window_sum_mc #(.NUM_CH(NUM_CH), .IN_W(IN_W), .WIN(WIN), .OUT_W(OUT_W), .EMIT_PARTIAL(0)) dut_f (
        .clock (clock),
        .reset (reset),
        .bus   (bus_f)
    );

    int          checks = 0;
    int          errors = 0;
    res_t        exp_p[$];
    res_t        exp_f[$];
    res_t        hold_p = '0;
    int unsigned hist[NUM_CH][$];
    bit          pend_f = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the window is literally the last WIN samples of the current line.
    task automatic model(input bit sol, input logic [DW-1:0] d);
        res_t        r;
        int unsigned s;
        if (sol)
            for (int k = 0; k < NUM_CH; k++) hist[k].delete();
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            hist[k].push_back(int'(d[k*IN_W +: IN_W]));
            if (hist[k].size() > WIN) void'(hist[k].pop_front());
            s = 0;
            for (int i = 0; i < hist[k].size(); i++) s += hist[k][i];
            r.sum[k*OUT_W +: OUT_W] = OUT_W'(s);
        end
        r.full = (hist[0].size() == WIN);
        r.sol  = sol;
        exp_p.push_back(r);
        if (sol) pend_f = 1'b1;
        if (r.full) begin
            r.sol  = pend_f;
            pend_f = 1'b0;
            exp_f.push_back(r);
        end
    endtask

    task automatic set_in(input bit v, input bit s, input logic [DW-1:0] d);
        bus_p.in_valid = v; bus_p.in_sol = s; bus_p.in_data = d;
        bus_f.in_valid = v; bus_f.in_sol = s; bus_f.in_data = d;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
        set_in(v, s, d);
        if (v) model(s, d);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, '0);
        exp_p.delete();
        exp_f.delete();
        for (int k = 0; k < NUM_CH; k++) hist[k].delete();
        pend_f = 1'b0;
        hold_p = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat2(input int i);
        logic [DW-1:0] d;
        d = '0;
        d[0 +: IN_W]    = IN_W'(i);
        d[IN_W +: IN_W] = IN_W'(2047);
        return d;
    endfunction

    task automatic stream2(input bit gaps);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, i == 1, pat2(i));
            if (gaps) idle(int'($urandom_range(1, 3)));
        end
    endtask

    task automatic check_final30(input string tag);
        @(negedge clock);
        check({tag, "_p_lane0"}, 64'(bus_p.out_sum[0 +: OUT_W]), 64'd30);
        check({tag, "_p_lane1"}, 64'(bus_p.out_sum[OUT_W +: OUT_W]), 64'd10235);
        check({tag, "_p_full"}, 64'(bus_p.out_full), 64'd1);
        check({tag, "_f_lane0"}, 64'(bus_f.out_sum[0 +: OUT_W]), 64'd30);
        @(posedge clock);
        #1;
    endtask

    // Monitor: pop-and-compare on every presented result.
    always @(negedge clock) begin
        res_t r;
        if (bus_p.out_valid === 1'b1) begin
            if (exp_p.size() == 0) begin
                check("p_unexpected_valid", 64'd1, 64'd0);
            end else begin
                r = exp_p.pop_front();
                check("p_sum", 64'(bus_p.out_sum), 64'(r.sum));
                check("p_full", 64'(bus_p.out_full), 64'(r.full));
                check("p_sol", 64'(bus_p.out_sol), 64'(r.sol));
                hold_p = r;
            end
        end else begin
            check("p_valid_known", 64'(bus_p.out_valid), 64'd0);
            check("p_hold_sum", 64'(bus_p.out_sum), 64'(hold_p.sum));
            check("p_hold_full", 64'(bus_p.out_full), 64'(hold_p.full));
        end
        if (bus_f.out_valid === 1'b1) begin
            if (exp_f.size() == 0) begin
                check("f_unexpected_valid", 64'd1, 64'd0);
            end else begin
                r = exp_f.pop_front();
                check("f_sum", 64'(bus_f.out_sum), 64'(r.sum));
                check("f_full", 64'(bus_f.out_full), 64'(r.full));
                check("f_sol", 64'(bus_f.out_sol), 64'(r.sol));
            end
        end
    end

    initial begin
        set_in(1'b0, 1'b0, '0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle after reset: everything stays at zero.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_valid", 64'(bus_p.out_valid), 64'd0);
            check("idle_sum", 64'(bus_p.out_sum), 64'd0);
            check("idle_full", 64'(bus_p.out_full), 64'd0);
        end
        @(posedge clock);
        #1;

        stream2(1'b0);
        idle(2);
        check_final30("cont");

        stream2(1'b1);
        idle(2);
        check_final30("gaps");

        // Restart mid-line after 7 samples.
        for (int i = 1; i <= 7; i++) step(1'b1, i == 1, pat2(i));
        step(1'b1, 1'b1, {IN_W'($urandom), IN_W'(9)});
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'($urandom));
        idle(2);

        // Reset right after the third sample drops the partial window.
        for (int i = 1; i <= 3; i++) step(1'b1, i == 1, pat2(i));
        do_reset();
        @(negedge clock);
        check("rst_valid", 64'(bus_p.out_valid), 64'd0);
        check("rst_sum", 64'(bus_p.out_sum), 64'd0);
        @(posedge clock);
        #1;
        stream2(1'b0);
        idle(2);
        check_final30("post_rst");

        // Randomised traffic with occasional line starts.
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit s;
            v = ($urandom_range(0, 9) < 7);
            s = v && ($urandom_range(0, 15) == 0);
            step(v, s, DW'($urandom));
        end
        idle(3);

        check("p_queue_drained", 64'(exp_p.size()), 64'd0);
        check("f_queue_drained", 64'(exp_f.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
